instr_queue_register: RTL
=========================

Name: instr_queue_register

Overview:
- Parametrised successor of the CPU instruction register.
- Buffers up to DEPTH fetched instruction words in a prefetch queue, with valid/ready handshakes on both sides.
- Presents the head entry to the control unit already split into opcode, operand and fetch PC.
- Sits between instruction-memory fetch and the control/ALU decode stage; the flush input serves branches and jumps.

Parameters:
DATA_WIDTH, 16, instruction word width
OPCODE_WIDTH, 4, opcode field width (word MSBs)
OPERAND_WIDTH, DATA_WIDTH-OPCODE_WIDTH (12), address/operand field width (word LSBs)
PC_WIDTH, 12, width of the fetch-PC tag stored with each entry
DEPTH, 4, queue entries; power of two, >=2
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width

Ports:
iclk  input  1  clock, rising-edge
irst_n  input  1  reset, asynchronous assert, active-low
iflush  input  1  discard all queued entries (branch/jump taken)
ins_valid  input  1  fetch side presents a word
ins_data  input  DATA_WIDTH  instruction word
ins_pc  input  PC_WIDTH  PC the word was fetched from
ins_ready  output  1  queue can accept a word this cycle
ir_valid  output  1  head entry valid
ir_ready  input  1  control unit consumes the head entry
opcode  output  OPCODE_WIDTH  ins_data[DATA_WIDTH-1 -: OPCODE_WIDTH] of head
address  output  OPERAND_WIDTH  ins_data[OPERAND_WIDTH-1:0] of head
ir_pc  output  PC_WIDTH  PC tag of head
count  output  CNT_WIDTH  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (irst_n=0), effective immediately:
  - Pointers and count = 0; ir_valid = 0.
  - opcode, address and ir_pc = 0; storage contents are don't-care.
- Push: ins_valid && ins_ready && !iflush at the rising edge writes {opcode, operand, pc} to the tail. The tail pointer wraps modulo DEPTH.
- Pop: ir_valid && ir_ready && !iflush advances the head, wrapping modulo DEPTH.
- Registered outputs: ir_valid, opcode, address, ir_pc and count all come from flops, with no combinational path from ins_* to the outputs.
- Latency: a word pushed into an empty queue in cycle N appears on the outputs, with ir_valid=1, in cycle N+1.
- ins_ready = (count < DEPTH) && !iflush. It is combinational from flops and iflush only, and never depends on ins_valid.
- Simultaneous push and pop:
  - count is unchanged.
  - Allowed only when count < DEPTH (full queue: ins_ready=0 even when a pop occurs).
  - When count==1, the pushed word becomes the head in the following cycle.
- Empty: ir_valid=0; opcode/address/ir_pc hold their last values; ir_ready is ignored.
- Full: ins_ready=0; a held ins_valid stalls without loss, and the word is accepted on the first cycle after a pop.
- Flush:
  - iflush=1 at an edge sets count=0, head=tail=0 and ir_valid=0 in the next cycle.
  - Any push or pop in the same cycle is dropped. Flush has priority over both.
  - The next push after flush lands one cycle later, per the normal latency.
- Reset mid-operation discards all entries; there is no partial state.
- Stability: while ir_valid=1 and ir_ready=0, opcode, address and ir_pc must not change.

Decomposition:
- Shared package CPU_package gains:
  - OPCODE_WIDTH, OPERAND_WIDTH, PC_WIDTH, IQ_DEPTH constants.
  - typedef struct packed {opcode, operand, pc} ir_entry_t.
- The existing DATA_WIDTH and ADDRESS_WIDTH continue to supply the defaults.
- One sub-module, iq_storage: a DEPTH x ir_entry_t register array with write port (tail, we) and read of head. Pointers, count, handshake and output register stay in instr_queue_register.

Test Plan:
1. Reset then a single push of ins_data=16'hA123, ins_pc=12'h010, with ir_ready=0.
   - Next cycle: ir_valid=1, opcode=4'hA, address=12'h123, ir_pc=12'h010, count=1.
   - Outputs hold while ir_ready=0.
2. Fill with 16'h1001..16'h1004 (DEPTH=4) while ir_ready=0.
   - count=4 and ins_ready=0; a fifth word 16'h1005 held valid is accepted only the cycle after one pop.
   - Pop order is 1001, 1002, 1003, 1004, 1005.
3. Streaming: push every cycle with ir_ready=1 held, 8 words.
   - count stays 1 after the first cycle.
   - Outputs show each word one cycle after its push, in order, across pointer wrap.
4. iflush with count=3, plus a coincident push (16'hBEEF) and pop.
   - Next cycle: count=0, ir_valid=0; BEEF is never output.
   - Next push 16'h2222 appears 1 cycle later.
5. Assert irst_n=0 asynchronously mid-stream with count=2.
   - Outputs go to 0, ir_valid=0 and count=0 without a clock edge.
   - After release, normal push/pop resumes from empty.

Source files
------------

// File: rtl/CPU_package.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | CPU_package: shared CPU widths plus the instruction-queue entry type  |
// | Rev 1.1 - adds opcode/operand/PC split and prefetch queue depth       |
// +----------------------------------------------------------------------+
package CPU_package;

  localparam int DATA_WIDTH    = 16;
  localparam int ADDRESS_WIDTH = 12;
  localparam int OPCODE_WIDTH  = 4;
  localparam int OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;
  localparam int PC_WIDTH      = ADDRESS_WIDTH;
  localparam int IQ_DEPTH      = 4;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [OPERAND_WIDTH-1:0] operand;
    logic [PC_WIDTH-1:0]      pc;
  } ir_entry_t;

endpackage
`default_nettype wire

// File: rtl/iq_storage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_storage: DEPTH-entry register array, one write port, one read     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iq_storage
  import CPU_package::*;
#(
  parameter int  DEPTH     = IQ_DEPTH,
  parameter int  PTR_WIDTH = $clog2(DEPTH),
  parameter type ENTRY_T   = ir_entry_t
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_WIDTH-1:0] waddr,
  input  ENTRY_T               wdata,
  input  logic [PTR_WIDTH-1:0] raddr,
  output ENTRY_T               rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  ENTRY_T mem_q [DEPTH];
  ENTRY_T mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_queue_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_queue_register: prefetch queue presenting a pre-split head IR  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_queue_register #(
  parameter int DATA_WIDTH    = CPU_package::DATA_WIDTH,
  parameter int OPCODE_WIDTH  = CPU_package::OPCODE_WIDTH,
  parameter int OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH,
  parameter int PC_WIDTH      = CPU_package::ADDRESS_WIDTH,
  parameter int DEPTH         = CPU_package::IQ_DEPTH,
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     iflush,
  input  logic                     ins_valid,
  input  logic [DATA_WIDTH-1:0]    ins_data,
  input  logic [PC_WIDTH-1:0]      ins_pc,
  output logic                     ins_ready,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [OPCODE_WIDTH-1:0]  opcode,
  output logic [OPERAND_WIDTH-1:0] address,
  output logic [PC_WIDTH-1:0]      ir_pc,
  output logic [CNT_WIDTH-1:0]     count
);

  localparam int                   c_ptr_w = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_full  = CNT_WIDTH'(DEPTH);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [OPERAND_WIDTH-1:0] operand;
    logic [PC_WIDTH-1:0]      pc;
  } entry_t;

  logic [c_ptr_w-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ir_valid_q, ir_valid_d;
  entry_t               out_q, out_d, wr_entry, rd_entry;
  logic                 ready, push, pop;

  assign wr_entry = '{opcode:  ins_data[DATA_WIDTH-1 -: OPCODE_WIDTH],
                      operand: ins_data[OPERAND_WIDTH-1:0],
                      pc:      ins_pc};

  assign ready = (count_q < c_full) && !iflush;
  assign push  = ins_valid && ready;
  assign pop   = ir_valid_q && ir_ready && !iflush;

  always_comb begin : p_ptrs
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (iflush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + c_ptr_w'(1);
      if (pop)  head_d = head_q + c_ptr_w'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
    ir_valid_d = (count_d != '0);
  end

  // The storage is read at the next head so the output register loads the
  // new head in the same edge; a word landing at that slot now is bypassed.
  always_comb begin : p_out
    out_d = out_q;
    if (!iflush && count_d != '0) begin
      out_d = (push && head_d == tail_q) ? wr_entry : rd_entry;
    end
  end

  iq_storage #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (c_ptr_w),
    .ENTRY_T   (entry_t)
  ) u_storage (
    .clk   (iclk),
    .we    (push),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_d),
    .rdata (rd_entry)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ir_valid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ir_valid_q <= ir_valid_d;
      out_q      <= out_d;
    end
  end

  assign ins_ready = ready;
  assign ir_valid  = ir_valid_q;
  assign opcode    = out_q.opcode;
  assign address   = out_q.operand;
  assign ir_pc     = out_q.pc;
  assign count     = count_q;

endmodule
`default_nettype wire
